// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// The request channel is valid/ready: mem_req stays high with mem_we/mem_addr/mem_wdata/mem_wstrb
// held stable until the cycle where mem_ready=1, and that cycle is the transfer; read data returns
// separately, qualified by mem_rvalid, in the transfer cycle or any later cycle.
interface riscv_lsu_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 32
);
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDR_LENGTH-1:0]   mem_addr;
  logic [WORD_LENGTH-1:0]   mem_wdata;
  logic [3:0]               mem_wstrb;
  logic                     mem_ready;
  logic                     mem_rvalid;
  logic [WORD_LENGTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: formats store lanes and strobes, aligns and extends loads,
// and stalls the pipeline while a data-memory transaction is outstanding.
module riscv_lsu #(
  parameter int WORD_LENGTH = 32,  // only 32 (four byte lanes) is meaningful
  parameter int ADDR_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   req_we,
  input  logic [2:0]             funct3,
  input  logic [ADDR_LENGTH-1:0] addr,
  input  logic [WORD_LENGTH-1:0] wdata,
  output logic                   stall,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] load_data,
  output logic                   load_valid,
  output logic                   fault,
  riscv_lsu_if.master            mem,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  logic       op_we;
  logic [2:0] op_funct3;
  logic [1:0] op_off;

  logic                   legal;
  logic [WORD_LENGTH-1:0] fmt_wdata;
  logic [3:0]             fmt_wstrb;

  assign dbg_state = state;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~addr[0];
      3'b010:         legal = (addr[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
  end

  // Loads present an all-zero strobe and data so the bus never sees stale lanes.
  always_comb begin
    fmt_wdata = '0;
    fmt_wstrb = 4'b0000;
    if (req_we) begin
      case (funct3[1:0])
        2'b00: begin
          fmt_wdata = {4{wdata[7:0]}};
          fmt_wstrb = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          fmt_wdata = {2{wdata[15:0]}};
          fmt_wstrb = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          fmt_wdata = wdata;
          fmt_wstrb = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    stall = (state == REQ) || (state == WAIT_R) || ((state == IDLE) && req_valid);
  end

  function automatic logic [WORD_LENGTH-1:0] extract(
    input logic [2:0]             f3,
    input logic [1:0]             off,
    input logic [WORD_LENGTH-1:0] rd
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'd0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'd0, h};
      default: extract = rd;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op_we         <= 1'b0;
      op_funct3     <= 3'b000;
      op_off        <= 2'b00;
      done          <= 1'b0;
      fault         <= 1'b0;
      load_valid    <= 1'b0;
      load_data     <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_wstrb <= 4'b0000;
    end else begin
      done       <= 1'b0;
      fault      <= 1'b0;
      load_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (legal) begin
              op_we         <= req_we;
              op_funct3     <= funct3;
              op_off        <= addr[1:0];
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= req_we;
              mem.mem_addr  <= {addr[ADDR_LENGTH-1:2], 2'b00};
              mem.mem_wdata <= fmt_wdata;
              mem.mem_wstrb <= fmt_wstrb;
              state         <= REQ;
            end else begin
              fault <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            if (op_we) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (mem.mem_rvalid) begin
              load_data  <= extract(op_funct3, op_off, mem.mem_rdata);
              done       <= 1'b1;
              load_valid <= 1'b1;
              state      <= DONE;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (mem.mem_rvalid) begin
            load_data  <= extract(op_funct3, op_off, mem.mem_rdata);
            done       <= 1'b1;
            load_valid <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: stores, loads, wait states, faults and mid-transaction reset.
module tb_riscv_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        load_valid;
  logic        fault;
  logic [1:0]  dbg_state;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  riscv_lsu_if #(.WORD_LENGTH(32), .ADDR_LENGTH(32)) mem_if ();

  riscv_lsu #(.WORD_LENGTH(32), .ADDR_LENGTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .load_valid (load_valid),
    .fault      (fault),
    .mem        (mem_if.master),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_load(input string tag);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, load_data);
    end else begin
      e = exp_q.pop_front();
      assert (load_data === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, load_data, e);
      end
    end
  endtask

  // driver
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    funct3    = f3;
    addr      = a;
    wdata     = d;
  endtask

  task automatic bus(input logic rdy, input logic rv, input logic [31:0] rd);
    mem_if.mem_ready  = rdy;
    mem_if.mem_rvalid = rv;
    mem_if.mem_rdata  = rd;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    funct3    = 3'b000;
    addr      = '0;
    wdata     = '0;
    bus(1'b0, 1'b0, 32'h0);
    tick();
    tick();

    // reset values
    check("rst_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_wstrb", {28'd0, mem_if.mem_wstrb}, 32'd0);
    rst = 1'b0;
    tick();

    // SB at 0x1003, zero-wait bus
    bus(1'b1, 1'b0, 32'h0);
    issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
    #1;
    check("sb_accept_stall", {31'd0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    #1;
    check("sb_mem_req", {31'd0, mem_if.mem_req}, 32'd1);
    check("sb_mem_we", {31'd0, mem_if.mem_we}, 32'd1);
    check("sb_mem_addr", mem_if.mem_addr, 32'h0000_1000);
    check("sb_mem_wdata", mem_if.mem_wdata, 32'hA5A5_A5A5);
    check("sb_mem_wstrb", {28'd0, mem_if.mem_wstrb}, 32'h8);
    check("sb_req_stall", {31'd0, stall}, 32'd1);
    check("sb_req_done", {31'd0, done}, 32'd0);
    tick();
    check("sb_done", {31'd0, done}, 32'd1);
    check("sb_load_valid", {31'd0, load_valid}, 32'd0);
    check("sb_done_stall", {31'd0, stall}, 32'd0);
    check("sb_done_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
    tick();
    check("sb_idle_done", {31'd0, done}, 32'd0);

    // SH at 0x0006
    issue(1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD);
    tick();
    req_valid = 1'b0;
    #1;
    check("sh_mem_wdata", mem_if.mem_wdata, 32'hABCD_ABCD);
    check("sh_mem_wstrb", {28'd0, mem_if.mem_wstrb}, 32'hC);
    tick();
    check("sh_done", {31'd0, done}, 32'd1);
    tick();

    // LB at 0x2001, data returned with the handshake
    bus(1'b1, 1'b1, 32'h1234_8000);
    exp_q.push_back(32'hFFFF_FF80);
    issue(1'b0, 3'b000, 32'h0000_2001, 32'h0);
    tick();
    req_valid = 1'b0;
    #1;
    check("lb_wstrb", {28'd0, mem_if.mem_wstrb}, 32'h0);
    check("lb_mem_we", {31'd0, mem_if.mem_we}, 32'd0);
    tick();
    check("lb_done", {31'd0, done}, 32'd1);
    check("lb_load_valid", {31'd0, load_valid}, 32'd1);
    check_load("lb_load_data");
    tick();

    // LBU at 0x2001
    exp_q.push_back(32'h0000_0080);
    issue(1'b0, 3'b100, 32'h0000_2001, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    check("lbu_load_valid", {31'd0, load_valid}, 32'd1);
    check_load("lbu_load_data");
    bus(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    check("lbu_hold", load_data, 32'h0000_0080);
    check("lbu_hold_lv", {31'd0, load_valid}, 32'd0);

    // LH at 0x2002: handshake first, data three cycles later
    bus(1'b1, 1'b0, 32'h0);
    exp_q.push_back(32'hFFFF_BEEF);
    issue(1'b0, 3'b001, 32'h0000_2002, 32'h0);
    tick();
    req_valid = 1'b0;
    #1;
    check("lh_req", {31'd0, mem_if.mem_req}, 32'd1);
    tick();
    bus(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("lh_wait_state", {30'd0, dbg_state}, 32'd2);
      check("lh_wait_stall", {31'd0, stall}, 32'd1);
      check("lh_wait_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
      check("lh_wait_done", {31'd0, done}, 32'd0);
      if (i == 2) bus(1'b0, 1'b1, 32'hBEEF_0000);
      tick();
    end
    bus(1'b0, 1'b0, 32'h0);
    check("lh_done", {31'd0, done}, 32'd1);
    check_load("lh_load_data");
    tick();

    // misaligned LW
    issue(1'b0, 3'b010, 32'h0000_3002, 32'h0);
    #1;
    check("lw_mis_stall", {31'd0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    #1;
    check("lw_mis_fault", {31'd0, fault}, 32'd1);
    check("lw_mis_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
    check("lw_mis_stall_after", {31'd0, stall}, 32'd0);
    tick();
    check("lw_mis_fault_pulse", {31'd0, fault}, 32'd0);
    check("lw_mis_mem_req2", {31'd0, mem_if.mem_req}, 32'd0);

    // illegal funct3
    issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);
    tick();
    req_valid = 1'b0;
    #1;
    check("f3_011_fault", {31'd0, fault}, 32'd1);
    check("f3_011_state", {30'd0, dbg_state}, 32'd0);
    tick();

    // SW with mem_ready low for five cycles; inputs wiggle meanwhile
    issue(1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF);
    tick();
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 3'b000, $urandom_range(0, 255), $urandom());
      #1;
      check("sw_hold_req", {31'd0, mem_if.mem_req}, 32'd1);
      check("sw_hold_addr", mem_if.mem_addr, 32'h0000_0040);
      check("sw_hold_wdata", mem_if.mem_wdata, 32'hDEAD_BEEF);
      check("sw_hold_wstrb", {28'd0, mem_if.mem_wstrb}, 32'hF);
      check("sw_hold_stall", {31'd0, stall}, 32'd1);
      check("sw_hold_done", {31'd0, done}, 32'd0);
      tick();
    end
    req_valid = 1'b0;
    bus(1'b1, 1'b0, 32'h0);
    tick();
    bus(1'b0, 1'b0, 32'h0);
    check("sw_done", {31'd0, done}, 32'd1);
    tick();

    // reset while waiting for read data
    bus(1'b1, 1'b0, 32'h0);
    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    bus(1'b0, 1'b0, 32'h0);
    check("rw_wait_state", {30'd0, dbg_state}, 32'd2);
    rst = 1'b1;
    #1;
    check("rw_rst_stall", {31'd0, stall}, 32'd0);
    check("rw_rst_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
    check("rw_rst_load_data", load_data, 32'd0);
    check("rw_rst_mem_addr", mem_if.mem_addr, 32'd0);
    check("rw_rst_state", {30'd0, dbg_state}, 32'd0);
    tick();
    rst = 1'b0;
    bus(1'b0, 1'b1, 32'h5555_5555);
    tick();
    check("rw_late_rvalid_lv", {31'd0, load_valid}, 32'd0);
    check("rw_late_rvalid_done", {31'd0, done}, 32'd0);
    tick();
    check("rw_late_rvalid_lv2", {31'd0, load_valid}, 32'd0);

    // fresh LW at 0x0
    bus(1'b1, 1'b1, 32'hCAFE_F00D);
    exp_q.push_back(32'hCAFE_F00D);
    issue(1'b0, 3'b010, 32'h0000_0000, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    bus(1'b0, 1'b0, 32'h0);
    check("lw0_load_valid", {31'd0, load_valid}, 32'd1);
    check_load("lw0_load_data");
    tick();
    check("lw0_idle", {30'd0, dbg_state}, 32'd0);
    check("leftover_expected", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit. Sits between the execute stage and the data-memory bus. Its load result feeds the writeback mux memory-data input.
- Formats store data into byte lanes with write strobes. Aligns and sign- or zero-extends load data.
- Holds the pipeline stalled while a bus transaction is outstanding.
- Runs a valid/ready request channel and a separate read-response channel toward memory.

Parameters:
- WORD_LENGTH, 32, data width; only 32 supported (4 byte lanes).
- ADDR_LENGTH, 32, address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  execute stage presents a memory operation.
- req_we  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  ADDR_LENGTH  effective byte address.
- wdata  input  WORD_LENGTH  store source register value.
- stall  output  1  pipeline hold request.
- done  output  1  one-cycle pulse: operation complete.
- load_data  output  WORD_LENGTH  extended load result, to writeback memory-data input.
- load_valid  output  1  load_data valid (pulses with done on loads).
- fault  output  1  one-cycle pulse: misaligned address or illegal funct3.
- mem_req  output  1  bus request valid.
- mem_we  output  1  bus write enable.
- mem_addr  output  ADDR_LENGTH  word-aligned address ({addr[ADDR_LENGTH-1:2],2'b00}).
- mem_wdata  output  WORD_LENGTH  lane-replicated store data.
- mem_wstrb  output  4  byte-lane write strobes; 0000 on loads.
- mem_ready  input  1  bus accepts the request this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  WORD_LENGTH  read word.

Behaviour:
- Reset (async, active-high) forces state IDLE and clears all registers.
- Reset values: all outputs 0, including mem_req, stall, done, load_valid, fault, load_data and mem_wstrb.
- Reset mid-transaction abandons the operation; mem_req drops immediately with reset.
- Legality check: illegal if funct3 ∉ {000,001,010,100,101}, or H/HU with addr[0]=1, or W with addr[1:0]≠00.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE, req_valid=1 and legal:
  - latch req_we, funct3, addr[1:0], mem_addr, mem_wdata, mem_wstrb;
  - go to REQ;
  - stall is asserted combinationally in this same cycle.
- IDLE, req_valid=1 and illegal:
  - fault=1 registered next cycle, for exactly one cycle;
  - no bus request; stay in IDLE;
  - stall=1 in the detect cycle only.
- REQ: mem_req=1 and request fields held stable until mem_ready=1.
  - Store with mem_ready: go to DONE.
  - Load with mem_ready and mem_rvalid in the same cycle: capture data, go to DONE.
  - Load with mem_ready only: go to WAIT_R.
- WAIT_R: mem_req=0. On mem_rvalid, capture mem_rdata and go to DONE.
- DONE:
  - done=1; load_valid=1 for loads;
  - stall=0, so the pipeline advances;
  - go to IDLE unconditionally.
- load_data holds its value until the next load completes.
- stall = (state∈{REQ,WAIT_R}) | (state==IDLE & req_valid).
- req_valid is ignored outside IDLE.
- Store formatting:
  - SB: wdata[7:0] replicated ×4; wstrb = 0001 << addr[1:0].
  - SH: wdata[15:0] replicated ×2; wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW: wdata unchanged; wstrb = 1111.
- Load extraction, registered at capture:
  - byte = rdata[8*addr[1:0] +: 8];
  - half = rdata[16*addr[1] +: 16];
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_rvalid outside REQ/WAIT_R, or during a store, is ignored.
- Minimum latency with a zero-wait bus: accept cycle → REQ (mem_ready & mem_rvalid) → DONE, i.e. done 2 cycles after acceptance.

Test Plan:
- SB, addr=0x1003, wdata=0x000000A5, mem_ready on first REQ cycle → mem_addr=0x1000, mem_wdata=0xA5A5A5A5, mem_wstrb=1000; done pulses 2 cycles after accept; load_valid=0.
- LB, addr=0x2001, mem_rdata=0x12348000 … byte1=0x80 → load_data=0xFFFFFF80. Same with LBU → 0x00000080.
- LH, addr=0x2002; mem_ready cycle 1, mem_rvalid 3 cycles later with rdata=0xBEEF0000 → WAIT_R holds stall=1 throughout; load_data=0xFFFFBEEF.
- LW, addr=0x3002 (misaligned) → fault=1 for one cycle; mem_req never rises. funct3=011 → fault=1.
- mem_ready held low 5 cycles in REQ → mem_req, mem_addr, mem_wdata and mem_wstrb stable all 5 cycles; stall=1; no done.
- rst asserted while in WAIT_R → all outputs 0 immediately. A later mem_rvalid=1 produces no load_valid; a fresh LW at 0x0 completes normally.
